csr_unit: RTL and testbench

Machine-mode CSR unit for the RV32 core, the parametrised successor of the flat 4096-entry CSR array. It implements only the architected M-mode CSRs and performs CSRRW/CSRRS/CSRRC read-modify-write with illegal-access detection. It also handles trap entry and MRET, runs 64-bit cycle/instret counters, and exposes interrupt-pending and trap-vector outputs. It sits beside the register file and is driven by the controller.

---
 rtl/csr_pkg.sv | 48 ++++
 rtl/csr_counter64.sv | 32 +++
 rtl/csr_unit.sv | 152 +++++++++++++++
 tb/tb_csr_unit.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR unit: CSR addresses, operation
// encodings, mstatus/mie/mip bit positions and the read-modify-write helper.
package csr_pkg;

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_RW   = 2'b01,
    OP_RS   = 2'b10,
    OP_RC   = 2'b11
  } csr_op_e;

  localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
  localparam logic [11:0] ADDR_MISA      = 12'h301;
  localparam logic [11:0] ADDR_MIE       = 12'h304;
  localparam logic [11:0] ADDR_MTVEC     = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
  localparam logic [11:0] ADDR_MEPC      = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
  localparam logic [11:0] ADDR_MTVAL     = 12'h343;
  localparam logic [11:0] ADDR_MIP       = 12'h344;
  localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
  localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
  localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
  localparam logic [11:0] ADDR_CYCLE     = 12'hC00;
  localparam logic [11:0] ADDR_INSTRET   = 12'hC02;
  localparam logic [11:0] ADDR_CYCLEH    = 12'hC80;
  localparam logic [11:0] ADDR_INSTRETH  = 12'hC82;
  localparam logic [11:0] ADDR_MHARTID   = 12'hF14;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int IRQ_MTI      = 7;
  localparam int IRQ_MEI      = 11;

  localparam logic [31:0] MIE_MASK   = 32'h0000_0880;
  localparam logic [31:0] MISA_VALUE = 32'h4000_0100;

  function automatic logic [31:0] apply_op(csr_op_e op, logic [31:0] old_val, logic [31:0] wdata);
    case (op)
      OP_RW:   apply_op = wdata;
      OP_RS:   apply_op = old_val | wdata;
      OP_RC:   apply_op = old_val & ~wdata;
      default: apply_op = old_val;
    endcase
  endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with independently writable halves; an explicit
// write to one half overrides the increment for that half only.
module csr_counter64 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [31:0] lo,
  output logic [31:0] hi
);

  logic [63:0] count_reg;
  logic [63:0] count_next;

  // The unwritten half still sees the carry derived from the pre-edge value.
  always_comb begin
    count_next = count_reg + {63'b0, inc};
    if (wr_lo) count_next[31:0]  = wdata;
    if (wr_hi) count_next[63:32] = wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_reg <= '0;
    else        count_reg <= count_next;
  end

  assign lo = count_reg[31:0];
  assign hi = count_reg[63:32];

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR unit: architected M-mode CSRs with read-modify-write and
// illegal-access detection, trap entry/MRET handling and 64-bit counters.
module csr_unit
  import csr_pkg::*;
#(
  parameter logic [31:0] HART_ID     = 32'd0,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter bit          COUNTER_EN  = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        csr_valid,
  input  logic [1:0]  csr_op,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  input  logic        csr_src_zero,
  output logic [31:0] csr_rdata,
  output logic        csr_illegal,
  input  logic        instret_inc,
  input  logic        irq_timer,
  input  logic        irq_ext,
  input  logic        trap_valid,
  input  logic [31:0] trap_cause,
  input  logic [31:0] trap_pc,
  input  logic [31:0] trap_tval,
  input  logic        mret_valid,
  output logic [31:0] mepc,
  output logic [31:0] trap_vector,
  output logic        irq_pending
);

  csr_op_e     op;
  logic        mie_bit_reg, mpie_reg;
  logic [31:0] mie_reg, mtvec_reg, mscratch_reg, mepc_reg, mcause_reg, mtval_reg;
  logic [31:0] mstatus_val, mip_val, new_val, tvec_base;
  logic        implemented, suppress, active, write_en;

  logic [1:0]        cnt_inc, cnt_wr_lo, cnt_wr_hi;
  logic [1:0][31:0]  cnt_lo, cnt_hi;

  assign op = csr_op_e'(csr_op);

  always_comb begin
    mstatus_val                = '0;
    mstatus_val[12:11]         = 2'b11;
    mstatus_val[MSTATUS_MIE]   = mie_bit_reg;
    mstatus_val[MSTATUS_MPIE]  = mpie_reg;
    mip_val                    = '0;
    mip_val[IRQ_MTI]           = irq_timer;
    mip_val[IRQ_MEI]           = irq_ext;
  end

  always_comb begin
    csr_rdata   = '0;
    implemented = 1'b1;
    case (csr_addr)
      ADDR_MSTATUS:               csr_rdata = mstatus_val;
      ADDR_MISA:                  csr_rdata = MISA_VALUE;
      ADDR_MIE:                   csr_rdata = mie_reg;
      ADDR_MTVEC:                 csr_rdata = mtvec_reg;
      ADDR_MSCRATCH:              csr_rdata = mscratch_reg;
      ADDR_MEPC:                  csr_rdata = mepc_reg;
      ADDR_MCAUSE:                csr_rdata = mcause_reg;
      ADDR_MTVAL:                 csr_rdata = mtval_reg;
      ADDR_MIP:                   csr_rdata = mip_val;
      ADDR_MHARTID:               csr_rdata = HART_ID;
      ADDR_MCYCLE,   ADDR_CYCLE:    begin csr_rdata = cnt_lo[0]; implemented = COUNTER_EN; end
      ADDR_MCYCLEH,  ADDR_CYCLEH:   begin csr_rdata = cnt_hi[0]; implemented = COUNTER_EN; end
      ADDR_MINSTRET, ADDR_INSTRET:  begin csr_rdata = cnt_lo[1]; implemented = COUNTER_EN; end
      ADDR_MINSTRETH, ADDR_INSTRETH: begin csr_rdata = cnt_hi[1]; implemented = COUNTER_EN; end
      default:                    implemented = 1'b0;
    endcase
  end

  // Read-only space (addr[11:10]==11) is legal only when the write is suppressed.
  assign suppress    = ((op == OP_RS) || (op == OP_RC)) && csr_src_zero;
  assign active      = csr_valid && (op != OP_NONE);
  assign csr_illegal = active && (!implemented || ((csr_addr[11:10] == 2'b11) && !suppress));
  assign write_en    = active && !suppress && !csr_illegal && !trap_valid && !mret_valid;
  assign new_val     = apply_op(op, csr_rdata, csr_wdata);

  assign cnt_inc      = {instret_inc, 1'b1};
  assign cnt_wr_lo[0] = write_en && (csr_addr == ADDR_MCYCLE);
  assign cnt_wr_hi[0] = write_en && (csr_addr == ADDR_MCYCLEH);
  assign cnt_wr_lo[1] = write_en && (csr_addr == ADDR_MINSTRET);
  assign cnt_wr_hi[1] = write_en && (csr_addr == ADDR_MINSTRETH);

  generate
    if (COUNTER_EN) begin : g_counters
      for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
        csr_counter64 u_counter (
          .clk   (clk),
          .rst_n (rst_n),
          .inc   (cnt_inc[gi]),
          .wr_lo (cnt_wr_lo[gi]),
          .wr_hi (cnt_wr_hi[gi]),
          .wdata (new_val),
          .lo    (cnt_lo[gi]),
          .hi    (cnt_hi[gi])
        );
      end
    end else begin : g_no_counters
      assign cnt_lo = '0;
      assign cnt_hi = '0;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mie_bit_reg  <= 1'b0;
      mpie_reg     <= 1'b0;
      mie_reg      <= '0;
      mtvec_reg    <= MTVEC_RESET & ~32'h2;
      mscratch_reg <= '0;
      mepc_reg     <= '0;
      mcause_reg   <= '0;
      mtval_reg    <= '0;
    end else if (trap_valid) begin
      mepc_reg    <= trap_pc & ~32'h3;
      mcause_reg  <= trap_cause;
      mtval_reg   <= trap_tval;
      mpie_reg    <= mie_bit_reg;
      mie_bit_reg <= 1'b0;
    end else if (mret_valid) begin
      mie_bit_reg <= mpie_reg;
      mpie_reg    <= 1'b1;
    end else if (write_en) begin
      case (csr_addr)
        ADDR_MSTATUS: begin
          mie_bit_reg <= new_val[MSTATUS_MIE];
          mpie_reg    <= new_val[MSTATUS_MPIE];
        end
        ADDR_MIE:      mie_reg      <= new_val & MIE_MASK;
        ADDR_MTVEC:    mtvec_reg    <= new_val & ~32'h2;
        ADDR_MSCRATCH: mscratch_reg <= new_val;
        ADDR_MEPC:     mepc_reg     <= new_val & ~32'h3;
        ADDR_MCAUSE:   mcause_reg   <= new_val;
        ADDR_MTVAL:    mtval_reg    <= new_val;
        default: ;
      endcase
    end
  end

  // Vectored mode only applies to interrupts (cause MSB set).
  assign tvec_base   = {mtvec_reg[31:2], 2'b00};
  assign trap_vector = (mtvec_reg[0] && trap_cause[31])
                       ? tvec_base + {25'b0, trap_cause[4:0], 2'b00}
                       : tvec_base;
  assign mepc        = mepc_reg;
  assign irq_pending = mie_bit_reg && |(mie_reg & mip_val);

endmodule

// File: tb/tb_csr_unit.sv
// Self-checking bench for csr_unit: directed scenarios followed by randomized
// traffic checked every cycle against an architectural reference model.
module tb_csr_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        csr_valid = 1'b0;
  logic [1:0]  csr_op = 2'b00;
  logic [11:0] csr_addr = '0;
  logic [31:0] csr_wdata = '0;
  logic        csr_src_zero = 1'b0;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic        instret_inc = 1'b0;
  logic        irq_timer = 1'b0;
  logic        irq_ext = 1'b0;
  logic        trap_valid = 1'b0;
  logic [31:0] trap_cause = '0;
  logic [31:0] trap_pc = '0;
  logic [31:0] trap_tval = '0;
  logic        mret_valid = 1'b0;
  logic [31:0] mepc;
  logic [31:0] trap_vector;
  logic        irq_pending;

  csr_unit #(
    .HART_ID     (32'd3),
    .MTVEC_RESET (32'h0000_0100),
    .COUNTER_EN  (1'b1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .csr_valid    (csr_valid),
    .csr_op       (csr_op),
    .csr_addr     (csr_addr),
    .csr_wdata    (csr_wdata),
    .csr_src_zero (csr_src_zero),
    .csr_rdata    (csr_rdata),
    .csr_illegal  (csr_illegal),
    .instret_inc  (instret_inc),
    .irq_timer    (irq_timer),
    .irq_ext      (irq_ext),
    .trap_valid   (trap_valid),
    .trap_cause   (trap_cause),
    .trap_pc      (trap_pc),
    .trap_tval    (trap_tval),
    .mret_valid   (mret_valid),
    .mepc         (mepc),
    .trap_vector  (trap_vector),
    .irq_pending  (irq_pending)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Architectural state of the reference model.
  bit          m_mie_bit, m_mpie;
  logic [31:0] m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
  logic [63:0] m_cycle, m_instret;

  logic [11:0] addr_list [0:23] = '{
    12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
    12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80, 12'hC02,
    12'hC82, 12'hF14, 12'h7C0, 12'h000, 12'h306, 12'hC01, 12'hF11, 12'h340
  };

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %08h, expected %08h", tag, got, want);
    end
  endtask

  task automatic reset_model();
    m_mie_bit  = 1'b0;
    m_mpie     = 1'b0;
    m_mie      = '0;
    m_mtvec    = 32'h0000_0100;
    m_mscratch = '0;
    m_mepc     = '0;
    m_mcause   = '0;
    m_mtval    = '0;
    m_cycle    = '0;
    m_instret  = '0;
  endtask

  function automatic logic [31:0] model_mip();
    logic [31:0] v;
    v     = '0;
    v[7]  = irq_timer;
    v[11] = irq_ext;
    return v;
  endfunction

  // Returns 1 when the address is an implemented CSR; v is its current value.
  function automatic bit model_read(input logic [11:0] a, output logic [31:0] v);
    bit impl;
    impl = 1'b1;
    v    = '0;
    case (a)
      12'h300: begin v = 32'h0000_1800; v[3] = m_mie_bit; v[7] = m_mpie; end
      12'h301: v = 32'h4000_0100;
      12'h304: v = m_mie;
      12'h305: v = m_mtvec;
      12'h340: v = m_mscratch;
      12'h341: v = m_mepc;
      12'h342: v = m_mcause;
      12'h343: v = m_mtval;
      12'h344: v = model_mip();
      12'hB00, 12'hC00: v = m_cycle[31:0];
      12'hB80, 12'hC80: v = m_cycle[63:32];
      12'hB02, 12'hC02: v = m_instret[31:0];
      12'hB82, 12'hC82: v = m_instret[63:32];
      12'hF14: v = 32'd3;
      default: impl = 1'b0;
    endcase
    return impl;
  endfunction

  // One clock cycle: inputs are already driven (clock low). Check outputs
  // against the model, advance the model, then move to the next falling edge.
  task automatic step();
    logic [31:0] old_v, new_v, tv;
    bit impl, act, supp, ill, wr;
    #1;
    impl = model_read(csr_addr, old_v);
    act  = csr_valid && (csr_op != 2'b00);
    supp = csr_op[1] && csr_src_zero;
    ill  = act && (!impl || ((csr_addr[11:10] == 2'b11) && !supp));
    if (impl) check_eq("rdata", csr_rdata, old_v);
    check_eq("illegal", {31'b0, csr_illegal}, {31'b0, ill});
    check_eq("mepc", mepc, m_mepc);
    tv = m_mtvec & ~32'h3;
    if (m_mtvec[0] && trap_cause[31]) tv = tv + 32'(trap_cause[4:0]) * 4;
    check_eq("trap_vector", trap_vector, tv);
    check_eq("irq_pending", {31'b0, irq_pending}, {31'b0, m_mie_bit && ((m_mie & model_mip()) != 0)});
    $display("t=%0t v=%0b op=%0d addr=%03h wd=%08h rd=%08h ill=%0b trap=%0b mret=%0b",
             $time, csr_valid, csr_op, csr_addr, csr_wdata, csr_rdata, csr_illegal, trap_valid, mret_valid);

    wr = act && !supp && !ill && !trap_valid && !mret_valid;
    case (csr_op)
      2'b01:   new_v = csr_wdata;
      2'b10:   new_v = old_v | csr_wdata;
      default: new_v = old_v & ~csr_wdata;
    endcase
    m_cycle   = m_cycle + 64'd1;
    m_instret = m_instret + {63'b0, instret_inc};
    if (trap_valid) begin
      m_mepc    = trap_pc & ~32'h3;
      m_mcause  = trap_cause;
      m_mtval   = trap_tval;
      m_mpie    = m_mie_bit;
      m_mie_bit = 1'b0;
    end else if (mret_valid) begin
      m_mie_bit = m_mpie;
      m_mpie    = 1'b1;
    end else if (wr) begin
      case (csr_addr)
        12'h300: begin m_mie_bit = new_v[3]; m_mpie = new_v[7]; end
        12'h304: m_mie = new_v & 32'h0000_0880;
        12'h305: m_mtvec = new_v & ~32'h2;
        12'h340: m_mscratch = new_v;
        12'h341: m_mepc = new_v & ~32'h3;
        12'h342: m_mcause = new_v;
        12'h343: m_mtval = new_v;
        12'hB00: m_cycle[31:0] = new_v;
        12'hB80: m_cycle[63:32] = new_v;
        12'hB02: m_instret[31:0] = new_v;
        12'hB82: m_instret[63:32] = new_v;
        default: ;
      endcase
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [11:0] a,
                       input logic [31:0] wd, input logic sz);
    csr_valid    = v;
    csr_op       = op;
    csr_addr     = a;
    csr_wdata    = wd;
    csr_src_zero = sz;
  endtask

  task automatic access(input string tag, input logic [1:0] op, input logic [11:0] a,
                        input logic [31:0] wd, input logic sz, input bit chk_rd,
                        input logic [31:0] want_rd, input logic want_ill);
    drive(1'b1, op, a, wd, sz);
    #1;
    if (chk_rd) check_eq({tag, "_rdata"}, csr_rdata, want_rd);
    check_eq({tag, "_illegal"}, {31'b0, csr_illegal}, {31'b0, want_ill});
    step();
    drive(1'b0, 2'b00, 12'h000, 32'h0, 1'b0);
  endtask

  task automatic randomize_inputs();
    csr_valid    = ($urandom_range(0, 3) != 0);
    csr_op       = 2'($urandom_range(0, 3));
    csr_addr     = addr_list[$urandom_range(0, 23)];
    csr_wdata    = $urandom;
    csr_src_zero = ($urandom_range(0, 3) == 0);
    instret_inc  = 1'($urandom_range(0, 1));
    irq_timer    = 1'($urandom_range(0, 1));
    irq_ext      = 1'($urandom_range(0, 1));
    trap_valid   = ($urandom_range(0, 15) == 0);
    mret_valid   = ($urandom_range(0, 15) == 0);
    trap_cause   = $urandom;
    trap_pc      = $urandom;
    trap_tval    = $urandom;
  endtask

  initial begin
    reset_model();
    #1 rst_n = 1'b0;
    drive(1'b1, 2'b10, 12'h300, 32'h0, 1'b1);
    #1;
    check_eq("rst_mepc", mepc, 32'h0);
    check_eq("rst_irq_pending", {31'b0, irq_pending}, 32'h0);
    check_eq("rst_trap_vector", trap_vector, 32'h0000_0100);
    check_eq("rst_mstatus", csr_rdata, 32'h0000_1800);
    drive(1'b0, 2'b00, 12'h000, 32'h0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    access("mstatus",   2'b10, 12'h300, 32'h0, 1'b1, 1'b1, 32'h0000_1800, 1'b0);
    access("mtvec",     2'b10, 12'h305, 32'h0, 1'b1, 1'b1, 32'h0000_0100, 1'b0);
    access("mhartid",   2'b10, 12'hF14, 32'h0, 1'b1, 1'b1, 32'h0000_0003, 1'b0);
    access("mscr_rw",   2'b01, 12'h340, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h0, 1'b0);
    access("mscr_rs",   2'b10, 12'h340, 32'h0000_000F, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    access("mscr_rc",   2'b11, 12'h340, 32'h0000_00FF, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    access("mscr_rd",   2'b10, 12'h340, 32'h0, 1'b1, 1'b1, 32'hDEAD_BE00, 1'b0);
    access("cycle_rw",  2'b01, 12'hC00, 32'h5, 1'b0, 1'b0, 32'h0, 1'b1);
    access("cycle_rs0", 2'b10, 12'hC00, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    access("csr_7c0",   2'b01, 12'h7C0, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1);
    access("set_mie",   2'b10, 12'h300, 32'h8, 1'b0, 1'b1, 32'h0000_1800, 1'b0);
    access("set_mtie",  2'b10, 12'h304, 32'h80, 1'b0, 1'b1, 32'h0, 1'b0);
    irq_timer = 1'b1;
    #1 check_eq("irq_timer_pending", {31'b0, irq_pending}, 32'h1);
    step();
    access("mtvec_vec", 2'b01, 12'h305, 32'h0000_0101, 1'b0, 1'b1, 32'h0000_0100, 1'b0);
    trap_valid = 1'b1;
    trap_cause = 32'h8000_0007;
    trap_pc    = 32'h0000_0206;
    trap_tval  = 32'h0000_BEEF;
    #1 check_eq("trap_vector_vec", trap_vector, 32'h0000_011C);
    step();
    trap_valid = 1'b0;
    drive(1'b1, 2'b10, 12'h300, 32'h0, 1'b1);
    #1;
    check_eq("mepc_after_trap", mepc, 32'h0000_0204);
    check_eq("irq_after_trap", {31'b0, irq_pending}, 32'h0);
    access("mstat_trap", 2'b10, 12'h300, 32'h0, 1'b1, 1'b1, 32'h0000_1880, 1'b0);
    access("mcause",     2'b10, 12'h342, 32'h0, 1'b1, 1'b1, 32'h8000_0007, 1'b0);
    mret_valid = 1'b1;
    step();
    mret_valid = 1'b0;
    access("mstat_mret", 2'b10, 12'h300, 32'h0, 1'b1, 1'b1, 32'h0000_1888, 1'b0);
    access("mcyc_wr",    2'b01, 12'hB00, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0, 1'b0);
    access("mcyc_ff",    2'b10, 12'hB00, 32'h0, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0);
    access("mcyc_wrap",  2'b10, 12'hB00, 32'h0, 1'b1, 1'b1, 32'h0, 1'b0);
    access("mcych_carry", 2'b10, 12'hB80, 32'h0, 1'b1, 1'b1, 32'h1, 1'b0);
    trap_valid = 1'b1;
    trap_cause = 32'h0000_0002;
    access("trap_drop",  2'b01, 12'h340, 32'h1234_5678, 1'b0, 1'b1, 32'hDEAD_BE00, 1'b0);
    trap_valid = 1'b0;
    access("mscr_kept",  2'b10, 12'h340, 32'h0, 1'b1, 1'b1, 32'hDEAD_BE00, 1'b0);

    for (int i = 0; i < 1500; i++) begin
      randomize_inputs();
      step();
    end

    // Asynchronous reset in the middle of the low clock phase.
    drive(1'b1, 2'b10, 12'h300, 32'h0, 1'b1);
    trap_valid = 1'b0;
    mret_valid = 1'b0;
    trap_cause = 32'h0;
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_mepc", mepc, 32'h0);
    check_eq("mid_rst_mstatus", csr_rdata, 32'h0000_1800);
    check_eq("mid_rst_irq", {31'b0, irq_pending}, 32'h0);
    check_eq("mid_rst_trap_vector", trap_vector, 32'h0000_0100);
    reset_model();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    access("post_rst_mscr", 2'b10, 12'h340, 32'h0, 1'b1, 1'b1, 32'h0, 1'b0);
    for (int i = 0; i < 200; i++) begin
      randomize_inputs();
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
